// File: rtl/riscv32s_pkg.sv
// Shared riscv32s definitions: data-RAM depth and
// dump-engine state encoding.
package riscv32s_pkg;

    localparam int DMEM_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_READ,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } memdump_state_t;

endpackage

// File: rtl/memdump_halt_detect.sv
// End-of-program detector: sticky halt flag plus a
// saturating count of cycles spent running.
module memdump_halt_detect (
    input  logic        clock,
    input  logic        nreset,
    input  logic        dump_enable,
    input  logic [31:0] programaddress,
    input  logic [31:0] proglen,
    output logic        halt_req,
    output logic [31:0] run_cycles
);

    logic halted;

    // PC is a byte address, proglen counts words
    always_comb begin
        halt_req = !halted && dump_enable
                 && ((programaddress >> 2) >= proglen);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            halted     <= 1'b0;
            run_cycles <= '0;
        end else if (!halted) begin
            if (run_cycles != '1) begin
                run_cycles <= run_cycles + 32'd1;
            end
            if (halt_req) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memdump_engine.sv
// Freezes the core at end of program, then streams every
// data-RAM word out over a valid/ready channel.
module memdump_engine
    import riscv32s_pkg::*;
#(
    parameter int RAMDEPTH  = DMEM_WORDS,
    parameter int ADDRWIDTH = $clog2(RAMDEPTH)
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 dump_enable,
    input  logic [31:0]          programaddress,
    input  logic [31:0]          proglen,
    output logic                 core_hold,
    output logic                 ram_ren,
    output logic [ADDRWIDTH-1:0] ram_addr,
    input  logic [31:0]          ram_rdata,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [ADDRWIDTH-1:0] dump_index,
    output logic [31:0]          dump_data,
    output logic                 done,
    output logic [31:0]          run_cycles
);

    localparam logic [ADDRWIDTH-1:0] LAST =
        ADDRWIDTH'(RAMDEPTH - 1);

    memdump_state_t       state;
    logic [ADDRWIDTH-1:0] index;
    logic                 halt_req;

    memdump_halt_detect u_halt (
        .clock          (clock),
        .nreset         (nreset),
        .dump_enable    (dump_enable),
        .programaddress (programaddress),
        .proglen        (proglen),
        .halt_req       (halt_req),
        .run_cycles     (run_cycles)
    );

    // Outputs are registered: each is set on entry to the
    // state in which it must be visible.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_RUN;
            index      <= '0;
            core_hold  <= 1'b0;
            ram_ren    <= 1'b0;
            ram_addr   <= '0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state     <= ST_DRAIN;
                        core_hold <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    index    <= '0;
                    ram_addr <= '0;
                    ram_ren  <= 1'b1;
                    state    <= ST_READ;
                end
                ST_READ: begin
                    ram_ren <= 1'b0;
                    state   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    dump_data  <= ram_rdata;
                    dump_index <= index;
                    dump_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (index == LAST) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            index    <= index + 1'b1;
                            ram_addr <= index + 1'b1;
                            ram_ren  <= 1'b1;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
